// File: rtl/sum_acc_pkg.sv
// Shared types and default sizes for the block sum accumulator.
// Imported by sum_accumulator.
package sum_acc_pkg;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_ACC_WIDTH = 40;
   localparam int DEF_CNT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/sum_accumulator.sv
// Block accumulator: sums block_len unsigned beats, then holds the result
// until the consumer takes it.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, block_len      block request, accepted only in IDLE
//   in_valid/in_ready     beat handshake, in_data zero-extended into sum
//   out_valid/out_ready   result handshake
//   out_sum, out_count    accumulated sum (wraps) and beats accepted
//   overflow              sticky carry-out of the accumulator this block
module sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] block_len,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 overflow
);

   state_e state_q;
   state_e state_d;

   logic [CNT_WIDTH-1:0] len_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [ACC_WIDTH-1:0] sum_q;
   logic                 ovf_q;

   logic                 beat;
   logic                 last_beat;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic [ACC_WIDTH:0]   sum_ext;

   // Handshake decodes come from state only, never from inputs.
   assign beat    = in_valid & (state_q == ST_ACCUM);
   assign cnt_inc = cnt_q + 1'b1;

   assign last_beat = beat & (cnt_inc == len_q);

   // One extra bit catches the carry out of the accumulator.
   assign sum_ext = {1'b0, sum_q}
                  + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (block_len != '0) begin
                  state_d = ST_ACCUM;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_ACCUM: begin
            if (last_beat) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_ACCUM: in_ready  = 1'b1;
         ST_DONE:  out_valid = 1'b1;
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Datapath: results are left untouched outside ACCUM so IDLE keeps
   // showing the previous block.
   always_ff @(posedge clk) begin
      if (reset) begin
         len_q <= '0;
         cnt_q <= '0;
         sum_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if ((state_q == ST_IDLE) && start) begin
            len_q <= block_len;
            cnt_q <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
         end else if (beat) begin
            cnt_q <= cnt_inc;
            sum_q <= sum_ext[ACC_WIDTH-1:0];
            ovf_q <= ovf_q | sum_ext[ACC_WIDTH];
         end
      end
   end

   assign out_sum   = sum_q;
   assign out_count = cnt_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator.
// Runs a default instance and a 33-bit accumulator instance side by side.
module tb_sum_accumulator;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  block_len;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        rdy_a;
   logic        vld_a;
   logic [39:0] sum_a;
   logic [7:0]  cnt_a;
   logic        ovf_a;

   logic        rdy_b;
   logic        vld_b;
   logic [32:0] sum_b;
   logic [7:0]  cnt_b;
   logic        ovf_b;

   int total;
   int bad;

   sum_accumulator u_a (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .block_len (block_len),
      .in_valid  (in_valid),
      .in_ready  (rdy_a),
      .in_data   (in_data),
      .out_valid (vld_a),
      .out_ready (out_ready),
      .out_sum   (sum_a),
      .out_count (cnt_a),
      .overflow  (ovf_a)
   );

   sum_accumulator #(
      .WIDTH     (32),
      .ACC_WIDTH (33),
      .CNT_WIDTH (8)
   ) u_b (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .block_len (block_len),
      .in_valid  (in_valid),
      .in_ready  (rdy_b),
      .in_data   (in_data),
      .out_valid (vld_b),
      .out_ready (out_ready),
      .out_sum   (sum_b),
      .out_count (cnt_b),
      .overflow  (ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic go(input logic [7:0] n);
      start     = 1'b1;
      block_len = n;
      step();
      start     = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic take();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      start     = 1'b0;
      block_len = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      step();
      step();

      chk("rst_ready", rdy_a, 0);
      chk("rst_valid", vld_a, 0);
      chk("rst_sum",   sum_a, 0);
      chk("rst_count", cnt_a, 0);
      chk("rst_ovf",   ovf_a, 0);
      reset = 1'b0;
      step();
      chk("idle_ready", rdy_a, 0);

      // Contiguous block of four beats.
      go(8'd4);
      chk("t1_ready", rdy_a, 1);
      chk("t1_valid0", vld_a, 0);
      beat(32'd5774);
      beat(32'd57);
      beat(32'd584);
      chk("t1_valid_early", vld_a, 0);
      beat(32'd5674);
      chk("t1_valid", vld_a, 1);
      chk("t1_sum",   sum_a, 12089);
      chk("t1_count", cnt_a, 4);
      chk("t1_ovf",   ovf_a, 0);
      chk("t1_rdy_done", rdy_a, 0);
      take();
      chk("t1_idle_valid", vld_a, 0);
      chk("t1_idle_ready", rdy_a, 0);
      chk("t1_idle_sum", sum_a, 12089);

      // Same beats with gaps; a late block_len change must not matter.
      go(8'd4);
      block_len = 8'd1;
      beat(32'd5774);
      step(); step(); step();
      chk("t2_gap_count", cnt_a, 1);
      chk("t2_gap_sum",   sum_a, 5774);
      beat(32'd57);
      step(); step(); step();
      beat(32'd584);
      step(); step(); step();
      chk("t2_gap_valid", vld_a, 0);
      beat(32'd5674);
      chk("t2_valid", vld_a, 1);
      chk("t2_sum",   sum_a, 12089);
      chk("t2_count", cnt_a, 4);

      // Backpressure in DONE with a stray start.
      for (int i = 0; i < 5; i++) begin
         start     = (i == 2);
         block_len = 8'd3;
         step();
         chk("t3_hold_valid", vld_a, 1);
         chk("t3_hold_sum",   sum_a, 12089);
         chk("t3_hold_ready", rdy_a, 0);
      end
      start     = 1'b1;
      block_len = 8'd2;
      take();
      start = 1'b0;
      chk("t3_idle_valid", vld_a, 0);
      chk("t3_idle_ready", rdy_a, 0);
      step();
      chk("t3_start_ign", rdy_a, 0);
      chk("t3_start_ign_v", vld_a, 0);

      // Carry out of a 33-bit accumulator.
      go(8'd3);
      beat(32'hFFFF_FFFF);
      beat(32'hFFFF_FFFF);
      chk("t4_ovf_early", ovf_b, 0);
      beat(32'hFFFF_FFFF);
      chk("t4_valid", vld_b, 1);
      chk("t4_sum_b", sum_b, 64'h0_FFFF_FFFD);
      chk("t4_ovf_b", ovf_b, 1);
      chk("t4_sum_a", sum_a, 64'h2_FFFF_FFFD);
      chk("t4_ovf_a", ovf_a, 0);
      take();
      chk("t4_idle_ovf", ovf_b, 1);
      go(8'd1);
      chk("t4_clr_ovf", ovf_b, 0);
      beat(32'd5);
      chk("t4b_valid", vld_b, 1);
      chk("t4b_sum",   sum_b, 5);
      chk("t4b_ovf",   ovf_b, 0);
      chk("t4b_count", cnt_b, 1);
      take();

      // Zero-length block.
      go(8'd0);
      chk("t5_valid", vld_a, 1);
      chk("t5_sum",   sum_a, 0);
      chk("t5_count", cnt_a, 0);
      chk("t5_ready", rdy_a, 0);
      take();
      chk("t5_idle", vld_a, 0);

      // Reset mid-block.
      go(8'd4);
      beat(32'd100);
      beat(32'd200);
      chk("t6_part_sum", sum_a, 300);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_rst_sum",   sum_a, 0);
      chk("t6_rst_count", cnt_a, 0);
      chk("t6_rst_ready", rdy_a, 0);
      chk("t6_rst_valid", vld_a, 0);
      chk("t6_rst_ovf",   ovf_a, 0);
      go(8'd4);
      beat(32'd1);
      beat(32'd2);
      beat(32'd3);
      beat(32'd4);
      chk("t6_valid", vld_a, 1);
      chk("t6_sum",   sum_a, 10);
      chk("t6_count", cnt_a, 4);
      take();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
